// File: rtl/riscuva_pkg.sv
// Shared types and constants for the RISCuva interrupt controller.
package riscuva_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } intc_state_t;

  localparam int unsigned INTC_IDX_W = 3;

  localparam logic [1:0] INTC_PENDING = 2'd0;
  localparam logic [1:0] INTC_MASK    = 2'd1;
  localparam logic [1:0] INTC_VECTOR  = 2'd2;
  localparam logic [1:0] INTC_MODE    = 2'd3;

  localparam logic [7:0] VEC_NONE = 8'hFF;

endpackage

// File: rtl/intc_prio_enc.sv
// Fixed-priority encoder: reports the lowest set bit index (bit 0 wins).
module intc_prio_enc
  import riscuva_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]          i_vec,
  output logic                  o_found,
  output logic [INTC_IDX_W-1:0] o_idx
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_found = 1'b1;
        o_idx   = INTC_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/riscuva_intc.sv
// Eight-source fixed-priority interrupt controller driving the RISCuva intReq/intAck pair.
module riscuva_intc
  import riscuva_pkg::*;
#(
  parameter int unsigned N_SRC     = 8,
  parameter logic [7:0]  BASE_ADDR = 8'hF0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq,
  input  logic [7:0]       portAddress,
  input  logic             portRead,
  input  logic             portWrite,
  input  logic [7:0]       dataOut,
  output logic [7:0]       rdData,
  output logic             intReq,
  input  logic             intAck
);

  logic [N_SRC-1:0]      r_sync1, r_sync2, r_sync3;
  logic [N_SRC-1:0]      r_mask, r_mode, r_pend_edge;
  logic [7:0]            r_vector;
  intc_state_t           r_state;

  logic [7:0]            w_off;
  logic                  w_hit, w_wr, w_rd, w_eoi;
  logic [1:0]            w_reg;
  logic [N_SRC-1:0]      w_wdata, w_w1c, w_rise, w_ack_clr;
  logic [N_SRC-1:0]      w_pending, w_eligible;
  logic                  w_found;
  logic [INTC_IDX_W-1:0] w_win_idx;

  intc_state_t           w_state_nxt;
  logic                  w_req_nxt;
  logic [7:0]            w_vec_nxt;
  logic                  w_ack_take;

  // Port decode: the window wraps with the 8-bit address arithmetic.
  assign w_off   = portAddress - BASE_ADDR;
  assign w_hit   = (w_off < 8'd4);
  assign w_reg   = w_off[1:0];
  assign w_wr    = portWrite & w_hit;
  assign w_rd    = portRead & w_hit;
  assign w_eoi   = w_wr && (w_reg == INTC_VECTOR);
  assign w_wdata = dataOut[N_SRC-1:0];
  assign w_w1c   = (w_wr && (w_reg == INTC_PENDING)) ? w_wdata : '0;

  // Level sources mirror the synchronized input; edge sources use the latched bit.
  assign w_rise     = r_sync2 & ~r_sync3;
  assign w_pending  = (r_mode & r_pend_edge) | (~r_mode & r_sync2);
  assign w_eligible = w_pending & r_mask;
  assign w_ack_clr  = w_ack_take ? (N_SRC'(1) << w_win_idx) : '0;

  intc_prio_enc #(.N(N_SRC)) u_prio (
    .i_vec   (w_eligible),
    .o_found (w_found),
    .o_idx   (w_win_idx)
  );

  always_comb begin
    rdData = 8'h00;
    if (w_rd) begin
      case (w_reg)
        INTC_PENDING: rdData = 8'(w_pending);
        INTC_MASK:    rdData = 8'(r_mask);
        INTC_VECTOR:  rdData = r_vector;
        INTC_MODE:    rdData = 8'(r_mode);
        default:      rdData = 8'h00;
      endcase
    end
  end

  // Request/service sequencing; the winner is re-evaluated on the acknowledge edge.
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = 1'b0;
    w_vec_nxt   = r_vector;
    w_ack_take  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = REQ;
          w_req_nxt   = 1'b1;
        end
      end
      REQ: begin
        if (!w_found) begin
          w_state_nxt = IDLE;
        end else if (intAck) begin
          w_ack_take  = 1'b1;
          w_vec_nxt   = {5'b0, w_win_idx};
          w_state_nxt = SERVICE;
        end else begin
          w_req_nxt = 1'b1;
        end
      end
      SERVICE: begin
        if (w_eoi) begin
          w_vec_nxt   = VEC_NONE;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      intReq   <= 1'b0;
      r_vector <= VEC_NONE;
    end else begin
      r_state  <= w_state_nxt;
      intReq   <= w_req_nxt;
      r_vector <= w_vec_nxt;
    end
  end

  // Synchronizers, config registers and edge-pending bits; a new edge beats a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_sync3     <= '0;
      r_mask      <= '0;
      r_mode      <= '0;
      r_pend_edge <= '0;
    end else begin
      r_sync1     <= irq;
      r_sync2     <= r_sync1;
      r_sync3     <= r_sync2;
      r_pend_edge <= r_mode & (w_rise | (r_pend_edge & ~(w_w1c | w_ack_clr)));
      if (w_wr && (w_reg == INTC_MASK)) r_mask <= w_wdata;
      if (w_wr && (w_reg == INTC_MODE)) r_mode <= w_wdata;
    end
  end

endmodule
